ytydla_cmac2mem_wb: RTL
=======================

YTYDLA_CMAC2MEM_WB -- requirements
Module: ytydla_cmac2mem_wb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: result buffer entries, power of two, at least 2.
REQ-002 SHALL have parameter ADDR_W, default 16: byte-address width into the 64 KiB core memory.
REQ-003 SHALL have port ytydla_core_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ytydla_core_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port cfg_start, input, 1 bit: single-cycle job start pulse.
REQ-006 SHALL have port cfg_base_addr, input, ADDR_W bits: job destination byte address, sampled on the start cycle.
REQ-007 SHALL have port cfg_count, input, 16 bits: number of 32-bit results in the job, sampled on the start cycle.
REQ-008 SHALL have port cmac2wb_valid, input, 1 bit: result valid from the CMAC.
REQ-009 SHALL have port cmac2wb_result, input, 32 bits: CMAC result word.
REQ-010 SHALL have port wb2cmac_ready, output, 1 bit: block accepts a result this cycle.
REQ-011 SHALL have port wb2mem_wr_en, output, 1 bit: memory write request.
REQ-012 SHALL have port wb2mem_addr, output, ADDR_W bits: write byte address, word-aligned.
REQ-013 SHALL have port wb2mem_data, output, 32 bits: write data, little-endian byte order.
REQ-014 SHALL have port mem2wb_wr_ack, input, 1 bit: memory accepted the current write.
REQ-015 SHALL have port wb_busy, output, 1 bit: a job is in progress.
REQ-016 SHALL have port wb_done, output, 1 bit: single-cycle job completion pulse.

Function
REQ-017 SHALL implement states IDLE, RUN and DONE.
REQ-018 SHALL, in IDLE on cfg_start with cfg_count nonzero, latch the base address with bits [1:0] forced to 0, latch the count, clear the accepted and written counters, and enter RUN.
REQ-019 SHALL, in IDLE on cfg_start with cfg_count equal to 0, enter DONE directly without issuing any write.
REQ-020 SHALL ignore cfg_start while in RUN or DONE.
REQ-021 SHALL drive wb2cmac_ready = RUN and FIFO not full and accepted < count; full is evaluated before any same-cycle pop.
REQ-022 SHALL push cmac2wb_result into the FIFO on each cycle where cmac2wb_valid and wb2cmac_ready are both high, and increment the accepted counter.
REQ-023 SHALL, whenever the FIFO is non-empty in RUN, assert wb2mem_wr_en with wb2mem_data equal to the FIFO head and wb2mem_addr equal to the current address.
REQ-024 SHALL hold wb2mem_wr_en, wb2mem_addr and wb2mem_data stable until a cycle in which mem2wb_wr_ack is high.
REQ-025 SHALL, on each acknowledged write, pop the FIFO, add 4 to the address modulo 2^ADDR_W (0xFFFC wraps to 0x0000), and increment the written counter.
REQ-026 SHALL ignore mem2wb_wr_ack when wb2mem_wr_en is low.
REQ-027 SHALL allow a push and a pop in the same cycle.
REQ-028 SHALL make a result first visible on wb2mem_data one cycle after the cycle it is accepted, so that a full-rate result stream with ack held high sustains one write per cycle.
REQ-029 SHALL enter DONE on the cycle after the acknowledge of the count-th write.
REQ-030 SHALL stay in DONE for exactly one cycle, assert wb_done only there, and then return to IDLE.
REQ-031 SHALL drive wb_busy high in RUN and DONE only.
REQ-032 SHALL drive wb2mem_wr_en low, and wb2mem_addr and wb2mem_data to 0, outside RUN.

Reset
REQ-033 SHALL, on assertion of ytydla_core_rst at any time including mid-job, immediately drive all outputs to 0, empty the FIFO, clear all counters and the latched configuration, and enter IDLE.
REQ-034 SHALL, after reset deassertion, act only on a new cfg_start; an aborted job never resumes.

Structure
REQ-035 SHALL take the state enum, the default FIFO_DEPTH, ADDR_W and the 4-byte word-size constant from the shared package ytydla_pkg.
REQ-036 SHALL implement the result buffer as the sub-module ytydla_wb_fifo: synchronous FIFO with push/pop, full/empty and a registered head.

Verification
REQ-037 SHALL cover: base 0x0320, count 3, results 5/6/7, ack always high -> writes of 5, 6, 7 to 0x0320, 0x0324, 0x0328 on consecutive cycles, then wb_done for one cycle.
REQ-038 SHALL cover: ack held low for 10 cycles, 8 results offered -> ready drops after 4 accepted, wr_en/addr/data stable throughout, no data lost once ack resumes.
REQ-039 SHALL cover: base 0xFFF8, count 3 -> addresses 0xFFF8, 0xFFFC, 0x0000.
REQ-040 SHALL cover: count 0 -> no wr_en, wb_done one cycle after start; a second start issued during RUN -> no effect.
REQ-041 SHALL cover: reset asserted after 2 of 5 writes -> all outputs 0 immediately; a new start with count 1 then behaves normally.
REQ-042 SHALL cover: base 0x0323 -> first write address 0x0320; 6 results offered for count 4 -> ready low after the 4th is accepted.

Source files
------------

// File: rtl/ytydla_pkg.sv
// Shared types and constants for the CMAC-to-memory writeback path.
package ytydla_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

    localparam int WB_FIFO_DEPTH = 4;
    localparam int WB_ADDR_W     = 16;
    localparam int WORD_BYTES    = 4;

endpackage

// File: rtl/ytydla_wb_fifo.sv
// Small synchronous result FIFO with a registered head word, so the
// consumer sees a flop output rather than an array read mux.
module ytydla_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0]             cnt;
    logic                    push_ok, pop_ok;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_nxt  = rd_ptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok)
                rd_ptr <= rd_nxt;
            unique case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // Head follows the next-oldest entry; a push into an empty (or
            // draining-to-empty) FIFO bypasses straight into the head.
            if (pop_ok) begin
                if (cnt == (AW+1)'(1)) begin
                    if (push_ok)
                        head <= wdata;
                end else begin
                    head <= mem[rd_nxt];
                end
            end else if (push_ok && empty) begin
                head <= wdata;
            end
        end
    end

endmodule

// File: rtl/ytydla_cmac2mem_wb.sv
// Writeback engine: buffers CMAC results and streams them as 32-bit writes
// to consecutive word addresses starting at the job base address.
module ytydla_cmac2mem_wb
    import ytydla_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int ADDR_W     = WB_ADDR_W
) (
    input  logic              ytydla_core_clk,
    input  logic              ytydla_core_rst,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [15:0]       cfg_count,
    input  logic              cmac2wb_valid,
    input  logic [31:0]       cmac2wb_result,
    output logic              wb2cmac_ready,
    output logic              wb2mem_wr_en,
    output logic [ADDR_W-1:0] wb2mem_addr,
    output logic [31:0]       wb2mem_data,
    input  logic              mem2wb_wr_ack,
    output logic              wb_busy,
    output logic              wb_done
);
    wb_state_e         state;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       count_q, acc_q, wr_q;
    logic              run, fifo_full, fifo_empty, push, pop;
    logic [31:0]       fifo_head;

    assign run           = (state == ST_RUN);
    assign wb2cmac_ready = run && !fifo_full && (acc_q < count_q);
    assign push          = cmac2wb_valid && wb2cmac_ready;
    assign wb2mem_wr_en  = run && !fifo_empty;
    // An ack with no write outstanding must not pop or advance anything.
    assign pop           = wb2mem_wr_en && mem2wb_wr_ack;
    assign wb2mem_addr   = wb2mem_wr_en ? addr_q : '0;
    assign wb2mem_data   = wb2mem_wr_en ? fifo_head : '0;
    assign wb_busy       = (state == ST_RUN) || (state == ST_DONE);
    assign wb_done       = (state == ST_DONE);

    ytydla_wb_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk   (ytydla_core_clk),
        .rst   (ytydla_core_rst),
        .push  (push),
        .wdata (cmac2wb_result),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge ytydla_core_clk or posedge ytydla_core_rst) begin
        if (ytydla_core_rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            acc_q   <= '0;
            wr_q    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_count != 16'd0) begin
                            addr_q  <= {cfg_base_addr[ADDR_W-1:2], 2'b00};
                            count_q <= cfg_count;
                            acc_q   <= '0;
                            wr_q    <= '0;
                            state   <= ST_RUN;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (push)
                        acc_q <= acc_q + 16'd1;
                    if (pop) begin
                        addr_q <= addr_q + ADDR_W'(WORD_BYTES);
                        wr_q   <= wr_q + 16'd1;
                        if (wr_q == count_q - 16'd1)
                            state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
